// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, PS/2 protocol byte values and command result codes
// used by the PS/2 command sequencer.
package ps2_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSendOp,
        StTxwOp,
        StAckOp,
        StSendArg,
        StTxwArg,
        StAckArg,
        StBat,
        StFin
    } state_e;

    typedef enum logic [1:0] {
        ErrOk      = 2'd0,
        ErrTimeout = 2'd1,
        ErrRetry   = 2'd2,
        ErrBat     = 2'd3
    } cmd_err_e;

    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_BAT_ERR   = 8'hFC;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_CMD_LED   = 8'hED;

endpackage

// File: rtl/ps2_tmo_cntr.sv
// ps2_tmo_cntr: loadable down-counter; flags expiry on the enabled cycle in which it reaches 0.
module ps2_tmo_cntr #(
    parameter int unsigned WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_load,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // A window of N cycles expires on the N-th enabled cycle after the load.
    assign o_expired = i_en && (r_count <= WIDTH'(1));

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: sequences one PS/2 host command (opcode plus optional argument) through the
// transmitter, handling ACK/RESEND, ACK timeouts and the BAT result after a reset command.
module ps2_cmd_ctrl #(
    parameter int unsigned ACK_TMO_CYCLES = 750000,
    parameter int unsigned BAT_TMO_CYCLES = 25000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cmd_req,
    input  logic [7:0] i_cmd_opcode,
    input  logic       i_cmd_has_arg,
    input  logic [7:0] i_cmd_arg,
    output logic       o_cmd_busy,
    output logic       o_cmd_done,
    output logic [1:0] o_cmd_err,
    output logic       o_tx_wr_stb,
    output logic [7:0] o_tx_wr_data,
    input  logic       i_tx_ready,
    input  logic       i_tx_done,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data
);
    import ps2_pkg::*;

    localparam int unsigned TmrW     = $clog2(BAT_TMO_CYCLES + 1);
    localparam logic [2:0]  RetryMax = 3'(MAX_RETRY);

    state_e     r_state;
    logic [7:0] r_opcode;
    logic [7:0] r_arg;
    logic       r_has_arg;
    logic [2:0] r_retry;
    logic       r_busy;
    logic       r_done;
    logic [1:0] r_err;
    logic       r_stb;
    logic [7:0] r_tx_data;

    logic            w_rx_ack;
    logic            w_rx_resend;
    logic            w_rx_bat_ok;
    logic            w_rx_bat_err;
    logic            w_retry_out;
    logic [2:0]      w_retry_inc;
    logic            w_is_reset_cmd;
    logic            w_in_op;
    logic            w_tmr_load;
    logic            w_tmr_en;
    logic            w_expired;
    logic [TmrW-1:0] w_tmr_val;

    assign w_rx_ack       = i_rx_valid && (i_rx_data == PS2_ACK);
    assign w_rx_resend    = i_rx_valid && (i_rx_data == PS2_RESEND);
    assign w_rx_bat_ok    = i_rx_valid && (i_rx_data == PS2_BAT_OK);
    assign w_rx_bat_err   = i_rx_valid && (i_rx_data == PS2_BAT_ERR);
    assign w_retry_out    = (r_retry >= RetryMax);
    assign w_retry_inc    = (r_retry == 3'd7) ? r_retry : r_retry + 3'd1;
    assign w_is_reset_cmd = (r_opcode == PS2_CMD_RESET);
    assign w_in_op        = (r_state == StAckOp);

    assign w_tmr_en   = (r_state == StAckOp) || (r_state == StAckArg) || (r_state == StBat);
    // Arm the ACK window on frame completion, or the BAT window on the ACK to a reset command.
    assign w_tmr_load = (((r_state == StTxwOp) || (r_state == StTxwArg)) && i_tx_done) ||
                        (w_in_op && w_rx_ack && w_is_reset_cmd);
    assign w_tmr_val  = w_in_op ? TmrW'(BAT_TMO_CYCLES) : TmrW'(ACK_TMO_CYCLES);

    ps2_tmo_cntr #(
        .WIDTH(TmrW)
    ) u_tmo_cntr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load_val(w_tmr_val),
        .i_load    (w_tmr_load),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_opcode  <= '0;
            r_arg     <= '0;
            r_has_arg <= 1'b0;
            r_retry   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= ErrOk;
            r_stb     <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_stb  <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                StIdle, StFin: begin
                    r_state <= StIdle;
                    if (i_cmd_req) begin
                        r_opcode  <= i_cmd_opcode;
                        r_arg     <= i_cmd_arg;
                        r_has_arg <= i_cmd_has_arg;
                        r_retry   <= '0;
                        r_err     <= ErrOk;
                        r_busy    <= 1'b1;
                        r_state   <= StSendOp;
                    end
                end
                StSendOp, StSendArg: begin
                    if (i_tx_ready) begin
                        r_stb     <= 1'b1;
                        r_tx_data <= (r_state == StSendOp) ? r_opcode : r_arg;
                        r_state   <= (r_state == StSendOp) ? StTxwOp : StTxwArg;
                    end
                end
                StTxwOp: begin
                    if (i_tx_done) r_state <= StAckOp;
                end
                StTxwArg: begin
                    if (i_tx_done) r_state <= StAckArg;
                end
                StAckOp, StAckArg: begin
                    // A byte arriving in the expiry cycle takes precedence over the timeout.
                    if (w_rx_ack) begin
                        if (w_in_op && w_is_reset_cmd) begin
                            r_state <= StBat;
                        end else if (w_in_op && r_has_arg) begin
                            r_retry <= '0;
                            r_state <= StSendArg;
                        end else begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_err   <= ErrOk;
                        end
                    end else if (w_rx_resend) begin
                        if (w_retry_out) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_err   <= ErrRetry;
                        end else begin
                            r_retry <= w_retry_inc;
                            r_state <= w_in_op ? StSendOp : StSendArg;
                        end
                    end else if (w_expired) begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_err   <= ErrTimeout;
                    end
                end
                StBat: begin
                    if (w_rx_bat_ok || w_rx_bat_err || w_expired) begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        if (w_rx_bat_ok) begin
                            r_err <= ErrOk;
                        end else if (w_rx_bat_err) begin
                            r_err <= ErrBat;
                        end else begin
                            r_err <= ErrTimeout;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_busy   = r_busy;
    assign o_cmd_done   = r_done;
    assign o_cmd_err    = r_err;
    assign o_tx_wr_stb  = r_stb;
    assign o_tx_wr_data = r_tx_data;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// tb_ps2_cmd_ctrl: scoreboard bench; a reactive device model answers each transmitted frame
// from a per-command reply script, and a reference model predicts strobes and results.
module tb_ps2_cmd_ctrl;

    localparam int ACK_T = 40;
    localparam int BAT_T = 100;
    localparam int MAXR  = 3;

    localparam int R_ACK  = 0;
    localparam int R_RES  = 1;
    localparam int R_NONE = 2;
    localparam int B_OK   = 0;
    localparam int B_ERR  = 1;
    localparam int B_NONE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_req = 1'b0;
    logic [7:0] cmd_opcode = 8'h00;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_done = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       o_cmd_busy;
    logic       o_cmd_done;
    logic [1:0] o_cmd_err;
    logic       o_tx_wr_stb;
    logic [7:0] o_tx_wr_data;

    ps2_cmd_ctrl #(
        .ACK_TMO_CYCLES(ACK_T),
        .BAT_TMO_CYCLES(BAT_T),
        .MAX_RETRY     (MAXR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_req    (cmd_req),
        .i_cmd_opcode (cmd_opcode),
        .i_cmd_has_arg(cmd_has_arg),
        .i_cmd_arg    (cmd_arg),
        .o_cmd_busy   (o_cmd_busy),
        .o_cmd_done   (o_cmd_done),
        .o_cmd_err    (o_cmd_err),
        .o_tx_wr_stb  (o_tx_wr_stb),
        .o_tx_wr_data (o_tx_wr_data),
        .i_tx_ready   (tx_ready),
        .i_tx_done    (tx_done),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] err;
        bit         chk_lat;
        int         lat;
    } done_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ref_cyc = 0;
    int         n_txdone = 0;
    logic       rdy_q = 1'b1;
    logic [7:0] exp_b[$];
    done_t      exp_d[$];
    int         dev_rep[$];
    int         dev_bat = B_OK;
    bit         dev_op_ff = 1'b0;
    int         dev_fix_d = 0;
    int         dev_fix_bat_d = 0;
    int         rq[$];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= tx_ready;
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: walk the reply script frame by frame using the protocol rules.
    function automatic void model(input logic [7:0] op, input bit has_arg, input logic [7:0] arg,
                                  input int reps[$], input int bat);
        int    idx = 0;
        int    retries = 0;
        bit    in_arg = 1'b0;
        int    r;
        done_t d;
        while (1) begin
            exp_b.push_back(in_arg ? arg : op);
            r = (idx < reps.size()) ? reps[idx] : R_NONE;
            idx++;
            d.chk_lat = 1'b0;
            d.lat     = 0;
            if (r == R_NONE) begin
                d.err = 2'd1; d.chk_lat = 1'b1; d.lat = ACK_T;
                break;
            end
            if (r == R_RES) begin
                if (retries == MAXR) begin
                    d.err = 2'd2;
                    break;
                end
                retries++;
                continue;
            end
            if (!in_arg && op == 8'hFF) begin
                if (bat == B_OK) d.err = 2'd0;
                else if (bat == B_ERR) d.err = 2'd3;
                else begin d.err = 2'd1; d.chk_lat = 1'b1; d.lat = BAT_T; end
                break;
            end
            if (!in_arg && has_arg) begin
                in_arg  = 1'b1;
                retries = 0;
                continue;
            end
            d.err = 2'd0;
            break;
        end
        exp_d.push_back(d);
    endfunction

    // Monitor: every strobe and every done is checked against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_tx_wr_stb) begin
                chk("stb_with_ready", {31'd0, rdy_q}, 32'd1);
                if (exp_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_stb: got data 0x%0h, required no strobe",
                             o_tx_wr_data);
                end else begin
                    chk("tx_byte", {24'd0, o_tx_wr_data}, {24'd0, exp_b.pop_front()});
                end
            end
            if (o_cmd_done) begin
                done_t e;
                chk("busy_at_done", {31'd0, o_cmd_busy}, 32'd0);
                if (exp_d.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got err %0d, required no done", o_cmd_err);
                end else begin
                    e = exp_d.pop_front();
                    chk("cmd_err", {30'd0, o_cmd_err}, {30'd0, e.err});
                    if (e.chk_lat) chk("tmo_latency", cyc - ref_cyc, e.lat);
                end
            end
        end
    end

    task automatic send_rx(input int d, input logic [7:0] b);
        repeat (d - 1) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Device model: for each strobe, finish the frame, then answer from the script.
    initial begin : device_model
        int r;
        int d;
        int j;
        forever begin
            @(negedge clk);
            if (o_tx_wr_stb === 1'b1) begin
                tx_ready = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    rx_valid = 1'b1; rx_data = 8'hFA;
                    @(negedge clk);
                    rx_valid = 1'b0;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done  = 1'b0;
                tx_ready = 1'b1;
                ref_cyc  = cyc;
                n_txdone++;
                r = (dev_rep.size() > 0) ? dev_rep.pop_front() : R_NONE;
                if (r != R_NONE) begin
                    d = (dev_fix_d > 0) ? dev_fix_d :
                        (($urandom_range(0, 3) == 0) ? ACK_T : $urandom_range(1, ACK_T));
                    if (d >= 2 && $urandom_range(0, 2) == 0) begin
                        j = $urandom_range(1, d - 1);
                        send_rx(j, 8'h55);
                        d = d - j;
                    end
                    send_rx(d, (r == R_ACK) ? 8'hFA : 8'hFE);
                    if (r == R_ACK && dev_op_ff) begin
                        ref_cyc = cyc;
                        if (dev_bat != B_NONE) begin
                            d = (dev_fix_bat_d > 0) ? dev_fix_bat_d : $urandom_range(1, BAT_T);
                            send_rx(d, (dev_bat == B_OK) ? 8'hAA : 8'hFC);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (o_cmd_done) break;
            n++;
        end
        if (n >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL done_wait: got no cmd_done within 3000 cycles, required one");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [7:0] op, input bit has_arg, input logic [7:0] arg,
                           input int reps[$], input int bat, input bit drop, input int rdy_low);
        model(op, has_arg, arg, reps, bat);
        dev_rep   = reps;
        dev_bat   = bat;
        dev_op_ff = (op == 8'hFF);
        @(negedge clk);
        if (rdy_low > 0) tx_ready = 1'b0;
        cmd_req = 1'b1; cmd_opcode = op; cmd_has_arg = has_arg; cmd_arg = arg;
        @(negedge clk);
        cmd_req = 1'b0; cmd_opcode = 8'($urandom); cmd_arg = 8'($urandom);
        chk("busy_after_req", {31'd0, o_cmd_busy}, 32'd1);
        if (drop) begin
            cmd_req = 1'b1; cmd_opcode = 8'h11; cmd_has_arg = 1'b1; cmd_arg = 8'h22;
            @(negedge clk);
            cmd_req = 1'b0;
        end
        if (rdy_low > 0) begin
            repeat (rdy_low) @(negedge clk);
            tx_ready = 1'b1;
        end
        wait_done();
    endtask

    function automatic void set_reps(input int n, input int a, input int b, input int c,
                                     input int d, input int e);
        int v[5];
        v = '{a, b, c, d, e};
        rq.delete();
        for (int i = 0; i < n; i++) rq.push_back(v[i]);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, o_cmd_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_cmd_done}, 32'd0);
        chk({tag, "_err"}, {30'd0, o_cmd_err}, 32'd0);
        chk({tag, "_stb"}, {31'd0, o_tx_wr_stb}, 32'd0);
        chk({tag, "_data"}, {24'd0, o_tx_wr_data}, 32'd0);
    endtask

    initial begin : stimulus
        int start;
        int n;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_reps(2, R_ACK, R_ACK, 0, 0, 0);
        run_cmd(8'hED, 1'b1, 8'h07, rq, B_OK, 1'b1, 0);
        set_reps(3, R_RES, R_RES, R_ACK, 0, 0);
        run_cmd(8'hF4, 1'b0, 8'h00, rq, B_OK, 1'b0, 3);
        set_reps(5, R_ACK, R_RES, R_RES, R_RES, R_RES);
        run_cmd(8'hED, 1'b1, 8'h02, rq, B_OK, 1'b0, 0);
        set_reps(1, R_ACK, 0, 0, 0, 0);
        run_cmd(8'hFF, 1'b0, 8'h00, rq, B_OK, 1'b0, 0);
        run_cmd(8'hFF, 1'b0, 8'h00, rq, B_ERR, 1'b0, 0);
        run_cmd(8'hFF, 1'b0, 8'h00, rq, B_NONE, 1'b0, 0);
        dev_fix_bat_d = BAT_T;
        run_cmd(8'hFF, 1'b0, 8'h00, rq, B_OK, 1'b0, 0);
        dev_fix_bat_d = 0;
        set_reps(0, 0, 0, 0, 0, 0);
        run_cmd(8'hF4, 1'b0, 8'h00, rq, B_OK, 1'b0, 0);
        dev_fix_d = ACK_T;
        set_reps(1, R_ACK, 0, 0, 0, 0);
        run_cmd(8'hF4, 1'b0, 8'h00, rq, B_OK, 1'b0, 0);
        dev_fix_d = 0;

        // Reset while waiting for the argument ACK: no done, outputs cleared at once.
        set_reps(2, R_ACK, R_NONE, 0, 0, 0);
        dev_rep = rq; dev_bat = B_OK; dev_op_ff = 1'b0;
        exp_b.push_back(8'hED);
        exp_b.push_back(8'h3C);
        start = n_txdone;
        @(negedge clk);
        cmd_req = 1'b1; cmd_opcode = 8'hED; cmd_has_arg = 1'b1; cmd_arg = 8'h3C;
        @(negedge clk);
        cmd_req = 1'b0;
        n = 0;
        while (n_txdone < start + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_vec++; n_err++;
            $display("FAIL rst_setup: got %0d frames, required 2", n_txdone - start);
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_bytes_left", exp_b.size(), 0);
        set_reps(1, R_ACK, 0, 0, 0, 0);
        run_cmd(8'hF4, 1'b0, 8'h00, rq, B_OK, 1'b1, 0);

        for (int k = 0; k < 50; k++) begin
            logic [7:0] op;
            int         sel;
            sel = $urandom_range(0, 5);
            op  = (sel == 0) ? 8'hED : (sel == 1) ? 8'hF3 : (sel == 2) ? 8'hF4 :
                  (sel == 3) ? 8'hFF : (sel == 4) ? 8'hF2 : 8'($urandom);
            rq.delete();
            for (int i = 0; i < $urandom_range(1, 7); i++) begin
                sel = $urandom_range(0, 9);
                rq.push_back((sel < 6) ? R_ACK : (sel < 9) ? R_RES : R_NONE);
            end
            run_cmd(op, 1'($urandom), 8'($urandom), rq, $urandom_range(0, 2),
                    1'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 3) == 0) begin
                tx_done = 1'b1; rx_valid = 1'b1; rx_data = 8'hFA;
                @(negedge clk);
                tx_done = 1'b0; rx_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        chk("bytes_left", exp_b.size(), 0);
        chk("dones_left", exp_d.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
